execute_stage: RTL and testbench

Execute stage of the five-stage MIPS pipeline, sitting directly upstream of the data-memory stage. It takes decoded operands and control from ID/EX, computes the ALU result and zero flag, and owns the EX/MEM pipeline register that drives the memory stage's `zero`, `branch`, `memRead`, `memWrite`, `readData2Reg` and `aluRes` inputs. It also contains the iterative multiply/divide unit with its HI/LO registers, and raises a stall toward the hazard unit while that unit is busy.

---
 rtl/mips_ex_pkg.sv | 51 +++++
 rtl/execute_stage_if.sv | 47 ++++
 rtl/muldiv_unit.sv | 124 ++++++++++++
 rtl/execute_stage.sv | 110 +++++++++++
 tb/tb_execute_stage.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_ex_pkg.sv
// Shared definitions for the MIPS execute stage: ALU op codes, EX/MEM control bundle, mul/div FSM states.
// Pure declarations, no timing or backpressure of its own.
package mips_ex_pkg;

  localparam int MD_CYCLES_DEF = 32;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_AND   = 5'd2;
  localparam logic [4:0] ALU_OR    = 5'd3;
  localparam logic [4:0] ALU_XOR   = 5'd4;
  localparam logic [4:0] ALU_NOR   = 5'd5;
  localparam logic [4:0] ALU_SLT   = 5'd6;
  localparam logic [4:0] ALU_SLTU  = 5'd7;
  localparam logic [4:0] ALU_SLL   = 5'd8;
  localparam logic [4:0] ALU_SRL   = 5'd9;
  localparam logic [4:0] ALU_SRA   = 5'd10;
  localparam logic [4:0] ALU_LUI   = 5'd11;
  localparam logic [4:0] ALU_MULT  = 5'd12;
  localparam logic [4:0] ALU_MULTU = 5'd13;
  localparam logic [4:0] ALU_DIV   = 5'd14;
  localparam logic [4:0] ALU_DIVU  = 5'd15;
  localparam logic [4:0] ALU_MFHI  = 5'd16;
  localparam logic [4:0] ALU_MFLO  = 5'd17;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic branch;
    logic memRead;
    logic memWrite;
    logic regWrite;
    logic memToReg;
  } ex_ctrl_t;

  localparam ex_ctrl_t CTRL_BUBBLE = '0;

  // Ops that start the iterative unit; their low two bits are {div, unsigned}.
  function automatic logic isMulDiv(input logic [4:0] code);
    return (code >= ALU_MULT) && (code <= ALU_DIVU);
  endfunction

  // Ops that must wait for the iterative unit to be idle.
  function automatic logic usesHiLo(input logic [4:0] code);
    return (code >= ALU_MULT) && (code <= ALU_MFLO);
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX operands and control in, EX/MEM register out, plus flush and the hazard stall.
// Plain wires; timing and backpressure are owned by the execute stage.
interface execute_stage_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic [DW-1:0] readData1;
  logic [DW-1:0] readData2;
  logic [DW-1:0] immExt;
  logic [4:0]    shamt;
  logic [4:0]    aluCtrl;
  logic          aluSrc;
  logic          branchIn;
  logic          memReadIn;
  logic          memWriteIn;
  logic          regWriteIn;
  logic          memToRegIn;
  logic [4:0]    writeRegIn;
  logic          flush;

  logic          stall;
  logic          zero;
  logic          branch;
  logic          memRead;
  logic          memWrite;
  logic          regWrite;
  logic          memToReg;
  logic          ex_valid;
  logic [DW-1:0] aluRes;
  logic [DW-1:0] readData2Reg;
  logic [4:0]    writeReg;

  modport master (
    output in_valid, readData1, readData2, immExt, shamt, aluCtrl, aluSrc,
           branchIn, memReadIn, memWriteIn, regWriteIn, memToRegIn, writeRegIn, flush,
    input  stall, zero, branch, memRead, memWrite, regWrite, memToReg, ex_valid,
           aluRes, readData2Reg, writeReg
  );

  modport slave (
    input  in_valid, readData1, readData2, immExt, shamt, aluCtrl, aluSrc,
           branchIn, memReadIn, memWriteIn, regWriteIn, memToRegIn, writeRegIn, flush,
    output stall, zero, branch, memRead, memWrite, regWrite, memToReg, ex_valid,
           aluRes, readData2Reg, writeReg
  );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiply / restoring divide with HI/LO; MD_CYCLES cycles per op.
// start is only honoured in IDLE; busy stays high until HI/LO are written.
module muldiv_unit
  import mips_ex_pkg::*;
#(
  parameter int DW        = 32,
  parameter int MD_CYCLES = MD_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          busy,
  output logic [DW-1:0] hi,
  output logic [DW-1:0] lo
);

  localparam int CW = $clog2(MD_CYCLES + 1);

  md_state_e       state, nextState;
  logic [CW-1:0]   cnt;
  logic            isDiv, negRes, negRem, divZero;
  logic [DW-1:0]   aOrig, mcand, acc, low;

  logic            aNeg, bNeg;
  logic [DW-1:0]   aMag, bMag;
  logic [DW:0]     sum, remSh;
  logic [DW-1:0]   stepAcc, stepLow;
  logic [2*DW-1:0] prodFix;
  logic            lastStep;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MD_IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      MD_IDLE: if (start)    nextState = MD_BUSY;
      MD_BUSY: if (lastStep) nextState = MD_IDLE;
      default:               nextState = MD_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == MD_BUSY);
  end

  // Signed ops run on magnitudes; signs are reapplied when HI/LO are written.
  always_comb begin
    aNeg = ~op[0] & a[DW-1];
    bNeg = ~op[0] & b[DW-1];
    aMag = aNeg ? -a : a;
    bMag = bNeg ? -b : b;
  end

  always_comb begin
    lastStep = (state == MD_BUSY) && (cnt == CW'(1));
    sum      = {1'b0, acc} + {1'b0, (low[0] ? mcand : '0)};
    remSh    = {acc, low[DW-1]};
    stepAcc  = acc;
    stepLow  = low;
    if (isDiv) begin
      if (remSh >= {1'b0, mcand}) begin
        stepAcc = remSh[DW-1:0] - mcand;
        stepLow = {low[DW-2:0], 1'b1};
      end else begin
        stepAcc = remSh[DW-1:0];
        stepLow = {low[DW-2:0], 1'b0};
      end
    end else begin
      {stepAcc, stepLow} = {sum, low[DW-1:1]};
    end
    prodFix = negRes ? -{stepAcc, stepLow} : {stepAcc, stepLow};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      isDiv   <= 1'b0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      divZero <= 1'b0;
      aOrig   <= '0;
      mcand   <= '0;
      acc     <= '0;
      low     <= '0;
      hi      <= '0;
      lo      <= '0;
    end else if (state == MD_IDLE) begin
      if (start) begin
        cnt     <= CW'(MD_CYCLES);
        isDiv   <= op[1];
        negRes  <= aNeg ^ bNeg;
        negRem  <= aNeg;
        divZero <= (b == '0);
        aOrig   <= a;
        mcand   <= bMag;
        acc     <= '0;
        low     <= aMag;
      end
    end else begin
      cnt <= cnt - CW'(1);
      acc <= stepAcc;
      low <= stepLow;
      if (lastStep) begin
        if (!isDiv) begin
          hi <= prodFix[2*DW-1:DW];
          lo <= prodFix[DW-1:0];
        end else if (divZero) begin
          hi <= aOrig;
          lo <= '1;
        end else begin
          hi <= negRem ? -stepAcc : stepAcc;
          lo <= negRes ? -stepLow : stepLow;
        end
      end
    end
  end

endmodule

// File: rtl/execute_stage.sv
// MIPS execute stage: ALU, mul/div unit with HI/LO, and the EX/MEM pipeline register; ALU latency 1.
// stall is combinational: HI/LO users wait while mul/div is busy, capturing bubbles meanwhile.
module execute_stage
  import mips_ex_pkg::*;
#(
  parameter int DW        = 32,
  parameter int MD_CYCLES = MD_CYCLES_DEF
) (
  input logic        clk,
  input logic        rst_n,
  execute_stage_if.slave bus
);

  logic [DW-1:0] opB, aluOut, hi, lo;
  logic          mdBusy, mdStart, stallInt, capture;
  ex_ctrl_t      ctrlIn, ctrlQ;
  logic          zeroQ, validQ;
  logic [DW-1:0] aluResQ, rd2Q;
  logic [4:0]    writeRegQ;

  always_comb begin
    opB = bus.aluSrc ? bus.immExt : bus.readData2;
  end

  always_comb begin
    aluOut = '0;
    case (bus.aluCtrl)
      ALU_ADD:  aluOut = bus.readData1 + opB;
      ALU_SUB:  aluOut = bus.readData1 - opB;
      ALU_AND:  aluOut = bus.readData1 & opB;
      ALU_OR:   aluOut = bus.readData1 | opB;
      ALU_XOR:  aluOut = bus.readData1 ^ opB;
      ALU_NOR:  aluOut = ~(bus.readData1 | opB);
      ALU_SLT:  aluOut = {{(DW-1){1'b0}}, ($signed(bus.readData1) < $signed(opB))};
      ALU_SLTU: aluOut = {{(DW-1){1'b0}}, (bus.readData1 < opB)};
      ALU_SLL:  aluOut = opB << bus.shamt;
      ALU_SRL:  aluOut = opB >> bus.shamt;
      ALU_SRA:  aluOut = $signed(opB) >>> bus.shamt;
      ALU_LUI:  aluOut = opB << 16;
      ALU_MFHI: aluOut = hi;
      ALU_MFLO: aluOut = lo;
      default:  aluOut = '0;
    endcase
  end

  // A flushed mul/div must not start; a non-HI/LO op never waits on the unit.
  always_comb begin
    stallInt = bus.in_valid & mdBusy & usesHiLo(bus.aluCtrl);
    mdStart  = bus.in_valid & ~bus.flush & ~mdBusy & isMulDiv(bus.aluCtrl);
    capture  = bus.in_valid & ~bus.flush & ~stallInt;
    ctrlIn   = '{branch:   bus.branchIn,
                 memRead:  bus.memReadIn,
                 memWrite: bus.memWriteIn,
                 regWrite: bus.regWriteIn,
                 memToReg: bus.memToRegIn};
  end

  muldiv_unit #(
    .DW        (DW),
    .MD_CYCLES (MD_CYCLES)
  ) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mdStart),
    .op    (bus.aluCtrl[1:0]),
    .a     (bus.readData1),
    .b     (opB),
    .busy  (mdBusy),
    .hi    (hi),
    .lo    (lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrlQ     <= CTRL_BUBBLE;
      zeroQ     <= 1'b0;
      validQ    <= 1'b0;
      aluResQ   <= '0;
      rd2Q      <= '0;
      writeRegQ <= '0;
    end else if (capture) begin
      ctrlQ     <= ctrlIn;
      zeroQ     <= (aluOut == '0);
      validQ    <= 1'b1;
      aluResQ   <= aluOut;
      rd2Q      <= bus.readData2;
      writeRegQ <= bus.writeRegIn;
    end else begin
      ctrlQ     <= CTRL_BUBBLE;
      zeroQ     <= 1'b0;
      validQ    <= 1'b0;
      aluResQ   <= '0;
      rd2Q      <= '0;
      writeRegQ <= '0;
    end
  end

  assign bus.stall        = stallInt;
  assign bus.zero         = zeroQ;
  assign bus.branch       = ctrlQ.branch;
  assign bus.memRead      = ctrlQ.memRead;
  assign bus.memWrite     = ctrlQ.memWrite;
  assign bus.regWrite     = ctrlQ.regWrite;
  assign bus.memToReg     = ctrlQ.memToReg;
  assign bus.ex_valid     = validQ;
  assign bus.aluRes       = aluResQ;
  assign bus.readData2Reg = rd2Q;
  assign bus.writeReg     = writeRegQ;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU vector table, mul/div table, flush and reset corner sequences.
module tb_execute_stage;
  import mips_ex_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  execute_stage_if #(.DW(32)) bus();

  execute_stage #(.DW(32), .MD_CYCLES(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [4:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  sh;
    logic        src;
    logic        br;
    logic        mw;
    logic [31:0] expRes;
    logic        expZero;
  } vec_t;

  typedef struct {
    logic [4:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expLo;
    logic [31:0] expHi;
  } md_vec_t;

  vec_t    vecs[15];
  md_vec_t mdv[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idleIn();
    bus.in_valid   = 1'b0;
    bus.readData1  = '0;
    bus.readData2  = '0;
    bus.immExt     = '0;
    bus.shamt      = '0;
    bus.aluCtrl    = ALU_ADD;
    bus.aluSrc     = 1'b0;
    bus.branchIn   = 1'b0;
    bus.memReadIn  = 1'b0;
    bus.memWriteIn = 1'b0;
    bus.regWriteIn = 1'b0;
    bus.memToRegIn = 1'b0;
    bus.writeRegIn = '0;
    bus.flush      = 1'b0;
  endtask

  task automatic issue(input logic [4:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    idleIn();
    bus.in_valid  = 1'b1;
    bus.aluCtrl   = ctrl;
    bus.readData1 = a;
    bus.readData2 = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges while stall is high, checking every captured slot is a bubble.
  task automatic waitStall(output int n, output int bubbleErr);
    n = 0;
    bubbleErr = 0;
    while (bus.stall === 1'b1 && n < 100) begin
      step();
      n++;
      if (bus.ex_valid !== 1'b0) bubbleErr++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, be;

    vecs[0]  = '{ALU_ADD,  32'd5,        32'd3,        32'd0,      5'd0,  1'b0, 1'b0, 1'b0, 32'd8,        1'b0};
    vecs[1]  = '{ALU_SUB,  32'd7,        32'd7,        32'd0,      5'd0,  1'b0, 1'b1, 1'b0, 32'd0,        1'b1};
    vecs[2]  = '{ALU_SLT,  32'hFFFFFFFF, 32'd1,        32'd0,      5'd0,  1'b0, 1'b0, 1'b0, 32'd1,        1'b0};
    vecs[3]  = '{ALU_SLTU, 32'hFFFFFFFF, 32'd1,        32'd0,      5'd0,  1'b0, 1'b0, 1'b0, 32'd0,        1'b1};
    vecs[4]  = '{ALU_SRA,  32'd0,        32'h80000000, 32'd0,      5'd4,  1'b0, 1'b0, 1'b0, 32'hF8000000, 1'b0};
    vecs[5]  = '{ALU_ADD,  32'd0,        32'd8,        32'd5,      5'd0,  1'b1, 1'b0, 1'b1, 32'd5,        1'b0};
    vecs[6]  = '{ALU_AND,  32'h0000F0F0, 32'h0000FF00, 32'd0,      5'd0,  1'b0, 1'b0, 1'b0, 32'h0000F000, 1'b0};
    vecs[7]  = '{ALU_OR,   32'h0000F0F0, 32'h0000FF00, 32'd0,      5'd0,  1'b0, 1'b0, 1'b0, 32'h0000FFF0, 1'b0};
    vecs[8]  = '{ALU_XOR,  32'h0000F0F0, 32'h0000FF00, 32'd0,      5'd0,  1'b0, 1'b0, 1'b0, 32'h00000FF0, 1'b0};
    vecs[9]  = '{ALU_NOR,  32'd0,        32'd0,        32'd0,      5'd0,  1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0};
    vecs[10] = '{ALU_SLL,  32'd0,        32'd1,        32'd0,      5'd31, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0};
    vecs[11] = '{ALU_SRL,  32'd0,        32'h80000000, 32'd0,      5'd4,  1'b0, 1'b0, 1'b0, 32'h08000000, 1'b0};
    vecs[12] = '{ALU_LUI,  32'd0,        32'd0,        32'h1234,   5'd0,  1'b1, 1'b0, 1'b0, 32'h12340000, 1'b0};
    vecs[13] = '{ALU_ADD,  32'hFFFFFFFF, 32'd1,        32'd0,      5'd0,  1'b0, 1'b0, 1'b0, 32'd0,        1'b1};
    vecs[14] = '{5'd20,    32'd5,        32'd3,        32'd0,      5'd0,  1'b0, 1'b0, 1'b0, 32'd0,        1'b1};

    mdv[0] = '{ALU_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 32'hFFFFFFFF};
    mdv[1] = '{ALU_MULTU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 32'h00000001};
    mdv[2] = '{ALU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
    mdv[3] = '{ALU_DIV,   32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001};
    mdv[4] = '{ALU_DIVU,  32'd9,        32'd0,        32'hFFFFFFFF, 32'h00000009};

    // Reset state, with a live instruction presented to prove reset dominates.
    issue(ALU_ADD, 32'd5, 32'd3);
    bus.memWriteIn = 1'b1;
    repeat (3) step();
    chk("rst_aluRes",   bus.aluRes,   32'd0);
    chk("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("rst_zero",     {31'd0, bus.zero},     32'd0);
    chk("rst_memWrite", {31'd0, bus.memWrite}, 32'd0);
    chk("rst_stall",    {31'd0, bus.stall},    32'd0);
    idleIn();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 15; i++) begin
      idleIn();
      bus.in_valid   = 1'b1;
      bus.aluCtrl    = vecs[i].ctrl;
      bus.readData1  = vecs[i].a;
      bus.readData2  = vecs[i].b;
      bus.immExt     = vecs[i].imm;
      bus.shamt      = vecs[i].sh;
      bus.aluSrc     = vecs[i].src;
      bus.branchIn   = vecs[i].br;
      bus.memWriteIn = vecs[i].mw;
      bus.regWriteIn = ~vecs[i].mw;
      bus.writeRegIn = 5'(i + 1);
      step();
      chk($sformatf("v%0d_aluRes", i),   bus.aluRes, vecs[i].expRes);
      chk($sformatf("v%0d_zero", i),     {31'd0, bus.zero},     {31'd0, vecs[i].expZero});
      chk($sformatf("v%0d_valid", i),    {31'd0, bus.ex_valid}, 32'd1);
      chk($sformatf("v%0d_branch", i),   {31'd0, bus.branch},   {31'd0, vecs[i].br});
      chk($sformatf("v%0d_memWrite", i), {31'd0, bus.memWrite}, {31'd0, vecs[i].mw});
      chk($sformatf("v%0d_regWrite", i), {31'd0, bus.regWrite}, {31'd0, ~vecs[i].mw});
      chk($sformatf("v%0d_rd2Reg", i),   bus.readData2Reg, vecs[i].b);
      chk($sformatf("v%0d_writeReg", i), {27'd0, bus.writeReg}, 32'(i + 1));
    end

    idleIn();
    step();
    chk("idle_bubble", {31'd0, bus.ex_valid}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      issue(mdv[i].ctrl, mdv[i].a, mdv[i].b);
      step();
      chk($sformatf("md%0d_issue_valid", i), {31'd0, bus.ex_valid}, 32'd1);
      chk($sformatf("md%0d_issue_res", i),   bus.aluRes, 32'd0);
      issue(ALU_MFLO, 32'd0, 32'd0);
      #1;
      waitStall(n, be);
      chk($sformatf("md%0d_stall_cycles", i), 32'(n), 32'd32);
      chk($sformatf("md%0d_bubbles", i),      32'(be), 32'd0);
      step();
      chk($sformatf("md%0d_lo", i), bus.aluRes, mdv[i].expLo);
      chk($sformatf("md%0d_lo_valid", i), {31'd0, bus.ex_valid}, 32'd1);
      issue(ALU_MFHI, 32'd0, 32'd0);
      #1;
      chk($sformatf("md%0d_mfhi_nostall", i), {31'd0, bus.stall}, 32'd0);
      step();
      chk($sformatf("md%0d_hi", i), bus.aluRes, mdv[i].expHi);
    end

    // A plain ALU op slips through while the unit is busy.
    issue(ALU_MULT, 32'd6, 32'd7);
    step();
    issue(ALU_ADD, 32'd1, 32'd2);
    #1;
    chk("busy_add_nostall", {31'd0, bus.stall}, 32'd0);
    step();
    chk("busy_add_res",   bus.aluRes, 32'd3);
    chk("busy_add_valid", {31'd0, bus.ex_valid}, 32'd1);
    issue(ALU_MFLO, 32'd0, 32'd0);
    #1;
    waitStall(n, be);
    chk("busy_add_stall_cycles", 32'(n), 32'd31);
    step();
    chk("busy_add_lo", bus.aluRes, 32'd42);

    // Flush turns a store into a bubble.
    issue(ALU_ADD, 32'd0, 32'd8);
    bus.memWriteIn = 1'b1;
    bus.flush      = 1'b1;
    step();
    chk("flush_memWrite", {31'd0, bus.memWrite}, 32'd0);
    chk("flush_valid",    {31'd0, bus.ex_valid}, 32'd0);

    // A flushed MULT must not issue: LO keeps 42 and MFLO does not stall.
    issue(ALU_MULT, 32'd2, 32'd3);
    bus.flush = 1'b1;
    step();
    issue(ALU_MFLO, 32'd0, 32'd0);
    #1;
    chk("flush_mult_nostall", {31'd0, bus.stall}, 32'd0);
    step();
    chk("flush_mult_lo", bus.aluRes, 32'd42);

    // Reset ten cycles into a divide aborts it and clears HI/LO.
    issue(ALU_DIV, 32'd100, 32'd3);
    step();
    idleIn();
    repeat (10) step();
    issue(ALU_MFLO, 32'd0, 32'd0);
    #1;
    chk("pre_rst_stall", {31'd0, bus.stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", {31'd0, bus.stall}, 32'd0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_mflo",       bus.aluRes, 32'd0);
    chk("post_rst_mflo_valid", {31'd0, bus.ex_valid}, 32'd1);
    issue(ALU_MFHI, 32'd0, 32'd0);
    step();
    chk("post_rst_mfhi", bus.aluRes, 32'd0);

    idleIn();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
